// File: rtl/muldiv_unit_pkg.sv
// Shared types and opcode predicates for the multi-cycle multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULU  = 3'd0,
    MD_MUL   = 3'd1,
    MD_DIVU  = 3'd2,
    MD_DIV   = 3'd3,
    MD_MADDU = 3'd4,
    MD_MADD  = 3'd5,
    MD_MSUBU = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic is_signed(input md_op_t op);
    return (op inside {MD_MUL, MD_DIV, MD_MADD, MD_MSUB});
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op inside {MD_DIVU, MD_DIV});
  endfunction

  function automatic logic is_acc(input md_op_t op);
    return (op inside {MD_MADDU, MD_MADD, MD_MSUBU, MD_MSUB});
  endfunction

  function automatic logic is_sub(input md_op_t op);
    return (op inside {MD_MSUBU, MD_MSUB});
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring divide iteration on unsigned magnitudes.
module muldiv_div_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;
  logic           ge_s;

  assign trial_s = {rem_i, quot_i[WIDTH-1]};
  assign diff_s  = trial_s - {1'b0, dvs_i};
  assign ge_s    = (trial_s >= {1'b0, dvs_i});

  // Subtract-and-set when the shifted partial remainder covers the divisor.
  always_comb begin
    rem_o  = trial_s[WIDTH-1:0];
    quot_o = {quot_i[WIDTH-2:0], 1'b0};
    if (ge_s) begin
      rem_o  = diff_s[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = trial_s[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply, multiply-accumulate and divide unit with
// valid/ready handshakes, flush and result backpressure.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_op_t           in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             busy
);

  localparam int CW = $clog2(((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1);

  md_state_t          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mres_q;
  logic [WIDTH-1:0]   rem_q, quot_q, dvs_q, dvd_q;
  logic               qneg_q, rneg_q, dz_q;
  logic [WIDTH-1:0]   out_hi_q, out_lo_q;

  logic               sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [2*WIDTH-1:0] pmag_s, prod_s, acc_s, mres_s;
  logic [WIDTH-1:0]   rem_s, quot_s, q_fix_s, r_fix_s;

  assign sgn_s   = is_signed(in_op);
  assign a_neg_s = sgn_s & in_a[WIDTH-1];
  assign b_neg_s = sgn_s & in_b[WIDTH-1];
  assign mag_a_s = a_neg_s ? -in_a : in_a;
  assign mag_b_s = b_neg_s ? -in_b : in_b;

  // The product is formed once from the request operands and then aged in mres_q.
  assign pmag_s  = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
  assign prod_s  = (a_neg_s ^ b_neg_s) ? -pmag_s : pmag_s;
  assign acc_s   = {in_hi, in_lo};
  assign mres_s  = !is_acc(in_op) ? prod_s :
                   (is_sub(in_op) ? (acc_s - prod_s) : (acc_s + prod_s));

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvs_i  (dvs_q),
    .rem_o  (rem_s),
    .quot_o (quot_s)
  );

  assign q_fix_s = dz_q ? {WIDTH{1'b1}} : (qneg_q ? -quot_s : quot_s);
  assign r_fix_s = dz_q ? dvd_q : (rneg_q ? -rem_s : rem_s);

  // Control FSM, iteration counter and output result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      mres_q   <= {(2*WIDTH){1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quot_q   <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      out_hi_q <= {WIDTH{1'b0}};
      out_lo_q <= {WIDTH{1'b0}};
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && is_div(in_op)) begin
            state_q <= ST_DIV;
            cnt_q   <= CW'(WIDTH);
            rem_q   <= {WIDTH{1'b0}};
            quot_q  <= mag_a_s;
            dvs_q   <= mag_b_s;
            dvd_q   <= in_a;
            qneg_q  <= a_neg_s ^ b_neg_s;
            rneg_q  <= a_neg_s;
            dz_q    <= (in_b == {WIDTH{1'b0}});
          end else if (in_valid) begin
            if (MUL_LAT == 1) begin
              out_hi_q <= mres_s[2*WIDTH-1:WIDTH];
              out_lo_q <= mres_s[WIDTH-1:0];
              state_q  <= ST_DONE;
            end else begin
              mres_q  <= mres_s;
              cnt_q   <= CW'(MUL_LAT - 1);
              state_q <= ST_MUL;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_q == CW'(1)) begin
            out_hi_q <= mres_q[2*WIDTH-1:WIDTH];
            out_lo_q <= mres_q[WIDTH-1:0];
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DIV: begin
          rem_q  <= rem_s;
          quot_q <= quot_s;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_hi_q <= r_fix_s;
            out_lo_q <= q_fix_s;
            state_q  <= ST_DONE;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = resetn & (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV);
  assign out_valid = (state_q == ST_DONE);
  assign out_hi    = out_hi_q;
  assign out_lo    = out_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=3).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk       = 1'b0;
  logic         resetn    = 1'b0;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  md_op_t       in_op     = MD_MULU;
  logic [W-1:0] in_a      = 32'd0;
  logic [W-1:0] in_b      = 32'd0;
  logic [W-1:0] in_hi     = 32'd0;
  logic [W-1:0] in_lo     = 32'd0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_hi, out_lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;
  exp_t sbq[$];

  muldiv_unit #(.WIDTH(W), .MUL_LAT(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_hi(in_hi), .in_lo(in_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input md_op_t op, input logic [W-1:0] a, b, hi, lo);
    longint       sa, sb, q, r;
    logic [63:0]  up, sp, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    up  = {32'd0, a} * {32'd0, b};
    sp  = sa * sb;
    acc = {hi, lo};
    case (op)
      MD_MULU:  return up;
      MD_MUL:   return sp;
      MD_MADDU: return acc + up;
      MD_MADD:  return acc + sp;
      MD_MSUBU: return acc - up;
      MD_MSUB:  return acc - sp;
      MD_DIVU:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default:  return 64'd0;
    endcase
  endfunction

  // Issue one op at a negedge, wait for its result, hold it `hold` cycles, hand it off.
  task automatic run_op(input md_op_t op, input logic [W-1:0] a, b, hi, lo,
                        input logic [63:0] expv, input int hold);
    exp_t e;
    int   cyc;
    e.hi  = expv[63:32];
    e.lo  = expv[31:0];
    e.lat = is_div(op) ? (W + 1) : 3;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_hi = hi; in_lo = lo;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    chk("busy_cycle1", 64'(busy), 64'd1);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    e = sbq.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("out_hi", 64'(out_hi), 64'(e.hi));
    chk("out_lo", 64'(out_lo), 64'(e.lo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_hi", 64'(out_hi), 64'(e.hi));
      chk("hold_lo", 64'(out_lo), 64'(e.lo));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_valid", 64'(out_valid), 64'd0);
    chk("handoff_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic         seen;
    md_op_t       rop;
    logic [W-1:0] ra, rb, rh, rl;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_hi", 64'(out_hi), 64'd0);
    chk("rst_out_lo", 64'(out_lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(MD_MUL,  32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op(MD_MULU, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 64'h0000_0002_FFFF_FFFA, 0);
    run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op(MD_DIVU, 32'd7,         32'd0, 32'd0, 32'd0, 64'h0000_0007_FFFF_FFFF, 0);
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'h0000_0000_8000_0000, 0);
    run_op(MD_MSUB, 32'd2, 32'd3, 32'd0, 32'd5,         64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000, 0);
    run_op(MD_MUL,  32'd5, 32'd6, 32'd0, 32'd0, 64'd30, 5);
    run_op(MD_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'd1, 0);

    for (int i = 0; i < 8; i++) begin
      rop = md_op_t'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      rh  = $urandom;
      rl  = $urandom;
      run_op(rop, ra, rb, rh, rl, ref_op(rop, ra, rb, rh, rl), 0);
    end

    in_valid = 1'b1; in_op = MD_DIV; in_a = 32'd100; in_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_div_in_ready", 64'(in_ready), 64'd1);
    chk("flush_div_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    chk("flush_div_no_result", 64'(seen), 64'd0);

    flush = 1'b1; in_valid = 1'b1; in_op = MD_MUL; in_a = 32'd3; in_b = 32'd4;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    chk("flush_idle_no_result", 64'(seen), 64'd0);

    in_valid = 1'b1; in_op = MD_MUL; in_a = 32'd9; in_b = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_hi", 64'(out_hi), 64'd0);
    chk("rst_mid_out_lo", 64'(out_lo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("rst_mid_no_result", 64'(seen), 64'd0);
    chk("rst_mid_in_ready_after", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
